// File: rtl/phys_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// phys_mem_arbiter_pkg
//   Shared definitions for the physical memory port arbiter:
//   - OWNER_M0 / OWNER_M1 : encodings of the owning port (0 = mmu, 1 = DMA/VGA)
//   - DEF_*               : default widths and limits
//   - arb_state_t         : registered ownership state (owner + RMW lock)
//   - arb_choice()        : unheld port choice (priority + starvation/burst guard)
// -----------------------------------------------------------------------------
package phys_mem_arbiter_pkg;

   localparam logic OWNER_M0 = 1'b0;
   localparam logic OWNER_M1 = 1'b1;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MAX_WAIT   = 8;
   localparam int DEF_BURST_MAX  = 4;
   localparam int DEF_CNT_WIDTH  = 16;

   typedef struct packed {
      logic owner;   // port that presented the last access
      logic lock;    // port 0 holds the controller for an RMW sequence
   } arb_state_t;

   // Port choice when nothing forces the current owner to be kept.
   // Both requesting: port 0 wins unless port 1 has waited MAX_WAIT cycles;
   // once port 1 owns, it keeps the port until its burst budget is used up.
   function automatic logic arb_choice(input logic m0_req,
                                       input logic m1_req,
                                       input logic owner,
                                       input logic wait_full,
                                       input logic burst_full);
      logic c;
      c = owner;
      if (m0_req && !m1_req) begin
         c = OWNER_M0;
      end else if (!m0_req && m1_req) begin
         c = OWNER_M1;
      end else if (m0_req && m1_req) begin
         if (owner == OWNER_M1) begin
            c = burst_full ? OWNER_M0 : OWNER_M1;
         end else begin
            c = wait_full ? OWNER_M1 : OWNER_M0;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/phys_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// phys_mem_arbiter_if
//   Bundle of both master ports and the memory controller port.
//   modport slave  : arbiter view (takes requests, drives grants and dev_*)
//   modport master : environment view (the two masters plus the controller)
//
// Handshake: a master holds mX_req (with addr/wdata/we stable) until the
// cycle where mX_gnt=1 and mX_busy=0; that cycle completes the access and,
// for reads, m_rdata is valid in it. mX_busy = req && (!gnt || dev_busy).
// The controller sees one access per cycle on dev_*; dev_busy=1 means it is
// still working on the access presented by the current owner.
// -----------------------------------------------------------------------------
interface phys_mem_arbiter_if
   import phys_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   // port 0 (mmu)
   logic                  m0_req;
   logic                  m0_lock;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic                  m0_we;
   logic                  m0_gnt;
   logic                  m0_busy;
   // port 1 (DMA / VGA fetch)
   logic                  m1_req;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic                  m1_we;
   logic                  m1_gnt;
   logic                  m1_busy;
   // broadcast read data
   logic [DATA_WIDTH-1:0] m_rdata;
   // memory controller
   logic [ADDR_WIDTH-1:0] dev_addr;
   logic [DATA_WIDTH-1:0] dev_wdata;
   logic                  dev_is_write;
   logic [DATA_WIDTH-1:0] dev_rdata;
   logic                  dev_busy;

   modport slave (
      input  m0_req, m0_lock, m0_addr, m0_wdata, m0_we,
      input  m1_req, m1_addr, m1_wdata, m1_we,
      input  dev_rdata, dev_busy,
      output m0_gnt, m0_busy, m1_gnt, m1_busy, m_rdata,
      output dev_addr, dev_wdata, dev_is_write
   );

   modport master (
      output m0_req, m0_lock, m0_addr, m0_wdata, m0_we,
      output m1_req, m1_addr, m1_wdata, m1_we,
      output dev_rdata, dev_busy,
      input  m0_gnt, m0_busy, m1_gnt, m1_busy, m_rdata,
      input  dev_addr, dev_wdata, dev_is_write
   );

endinterface

// File: rtl/phys_mem_arbiter_sat_counter.sv
// -----------------------------------------------------------------------------
// arb_sat_counter
//   Saturating up-counter with synchronous clear; clear has priority.
//   Ports: clk, rst (async, active low), i_clr, i_inc, o_cnt (0..MAX).
// -----------------------------------------------------------------------------
module arb_sat_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_cnt
);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != MAX_VAL)) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/phys_mem_arbiter.sv
// -----------------------------------------------------------------------------
// phys_mem_arbiter
//   Shares the single physical memory controller port between port 0 (mmu)
//   and port 1 (DMA/VGA). Fixed port-0 priority with a starvation guard for
//   port 1, a burst limit on port 1 while port 0 waits, and an RMW lock for
//   port 0. Grants are zero-latency; dev_* are muxed from the selected port.
//   Ownership only moves in cycles where dev_busy=0.
//
//   Ports:
//     clk            system clock
//     rst            asynchronous, active-low reset
//     bus            phys_mem_arbiter_if.slave (masters + controller)
//     perf_conflict  cycles with both ports requesting      (MEM_ARB_PERF_EN)
//     perf_preempt   starvation pre-emptions of port 0       (MEM_ARB_PERF_EN)
//
//   Build option: define MEM_ARB_PERF_EN to add the wrapping perf counters.
// -----------------------------------------------------------------------------
module phys_mem_arbiter
   import phys_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_WAIT   = DEF_MAX_WAIT,
   parameter int BURST_MAX  = DEF_BURST_MAX,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef MEM_ARB_PERF_EN
   output logic [CNT_WIDTH-1:0] perf_conflict,
   output logic [CNT_WIDTH-1:0] perf_preempt,
`endif
   phys_mem_arbiter_if.slave    bus
);
   localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
   localparam int BURST_W = $clog2(BURST_MAX + 1);

   if (MAX_WAIT < 1 || BURST_MAX < 1 || CNT_WIDTH < 1) begin : g_param_check
      $error("phys_mem_arbiter: MAX_WAIT, BURST_MAX and CNT_WIDTH must be >= 1");
   end

   arb_state_t            r_state;
   logic [WAIT_W-1:0]     w_wait_cnt;
   logic [BURST_W-1:0]    w_burst_cnt;
   logic                  w_wait_full;
   logic                  w_burst_full;
   logic                  w_hold;
   logic                  w_choice;
   logic                  w_sel;
   logic                  w_gnt0;
   logic                  w_gnt1;
   logic                  w_busy0;
   logic                  w_busy1;
   logic                  w_is_write;
   logic                  w_wait_inc;
   logic                  w_burst_inc;
   logic                  w_burst_clr;
   logic                  w_lock_next;
   logic [ADDR_WIDTH-1:0] w_dev_addr;
   logic [DATA_WIDTH-1:0] w_dev_wdata;

   assign w_wait_full  = (w_wait_cnt == WAIT_W'(MAX_WAIT));
   assign w_burst_full = (w_burst_cnt == BURST_W'(BURST_MAX));

   // The owner is kept while the controller is mid-operation, while port 0
   // holds its RMW lock, and while reset is asserted (so dev_* show the
   // owner's values at reset).
   assign w_hold   = bus.dev_busy || (r_state.lock && (r_state.owner == OWNER_M0));
   assign w_choice = arb_choice(bus.m0_req, bus.m1_req, r_state.owner,
                                w_wait_full, w_burst_full);
   assign w_sel    = (!rst || w_hold) ? r_state.owner : w_choice;

   // Reset gates every control output low immediately, independent of clock.
   assign w_gnt0  = rst && bus.m0_req && (w_sel == OWNER_M0);
   assign w_gnt1  = rst && bus.m1_req && (w_sel == OWNER_M1);
   assign w_busy0 = rst && bus.m0_req && (!w_gnt0 || bus.dev_busy);
   assign w_busy1 = rst && bus.m1_req && (!w_gnt1 || bus.dev_busy);

   always_comb begin
      w_dev_addr  = bus.m0_addr;
      w_dev_wdata = bus.m0_wdata;
      w_is_write  = w_gnt0 && bus.m0_we;
      if (w_sel == OWNER_M1) begin
         w_dev_addr  = bus.m1_addr;
         w_dev_wdata = bus.m1_wdata;
         w_is_write  = w_gnt1 && bus.m1_we;
      end
   end

   assign bus.m0_gnt       = w_gnt0;
   assign bus.m1_gnt       = w_gnt1;
   assign bus.m0_busy      = w_busy0;
   assign bus.m1_busy      = w_busy1;
   assign bus.m_rdata      = bus.dev_rdata;
   assign bus.dev_addr     = w_dev_addr;
   assign bus.dev_wdata    = w_dev_wdata;
   assign bus.dev_is_write = w_is_write;

   // The lock is taken by a granted port-0 access with m0_lock set and then
   // persists while m0_lock stays high, even through cycles where port 0 has
   // no request (between the read and the write of an RMW).
   assign w_lock_next = bus.m0_lock && (w_sel == OWNER_M0) && (w_gnt0 || r_state.lock);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state.owner <= OWNER_M0;
         r_state.lock  <= 1'b0;
      end else begin
         r_state.owner <= w_sel;
         r_state.lock  <= w_lock_next;
      end
   end

   // Port 1 waiting time: counts cycles of unserved port-1 request.
   assign w_wait_inc = bus.m1_req && !w_gnt1;

   arb_sat_counter #(
      .WIDTH (WAIT_W),
      .MAX   (MAX_WAIT)
   ) u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (!w_wait_inc),
      .i_inc (w_wait_inc),
      .o_cnt (w_wait_cnt)
   );

   // Port 1 burst length: completed port-1 cycles since it last took over.
   assign w_burst_inc = w_gnt1 && !bus.dev_busy;
   assign w_burst_clr = (w_sel == OWNER_M0) && (r_state.owner == OWNER_M1);

   arb_sat_counter #(
      .WIDTH (BURST_W),
      .MAX   (BURST_MAX)
   ) u_burst_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_burst_clr),
      .i_inc (w_burst_inc),
      .o_cnt (w_burst_cnt)
   );

`ifdef MEM_ARB_PERF_EN
   logic [CNT_WIDTH-1:0] r_perf_conflict;
   logic [CNT_WIDTH-1:0] r_perf_preempt;
   logic                 w_conflict;
   logic                 w_preempt;

   assign w_conflict = bus.m0_req && bus.m1_req;
   // A pre-emption is the cycle where the starvation guard hands the port
   // from port 0 to port 1 while port 0 is still requesting.
   assign w_preempt  = w_conflict && !w_hold && (r_state.owner == OWNER_M0) && w_wait_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_conflict <= '0;
         r_perf_preempt  <= '0;
      end else begin
         if (w_conflict) begin
            r_perf_conflict <= r_perf_conflict + CNT_WIDTH'(1);
         end
         if (w_preempt) begin
            r_perf_preempt <= r_perf_preempt + CNT_WIDTH'(1);
         end
      end
   end

   assign perf_conflict = r_perf_conflict;
   assign perf_preempt  = r_perf_preempt;
`endif

endmodule
